// File: rtl/controller_reader.sv
// controller_reader: polls a serial game pad (latch strobe + 8 shifted bits) every POLL_CYCLES.
// Define CONTROLLER_SYNC_EN to add a 2-flop synchronizer on ctrl_data ahead of the sample point.
module controller_reader #(
    parameter int HALF_CYCLES = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ctrl_data,
    output logic       ctrl_latch,
    output logic       ctrl_pulse,
    output logic [7:0] controller,
    output logic       valid
);
    // state | meaning
    // IDLE  | waiting for a poll request
    // LATCH | latch strobe high for two half-periods
    // LOW   | pulse low, bit sampled on the last cycle
    // HIGH  | pulse high, pad shifts to the next bit
    // DONE  | publish shadow to controller, strobe valid
    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    localparam int            TW         = $clog2(2 * HALF_CYCLES);
    localparam logic [TW-1:0] LATCH_LOAD = TW'(2 * HALF_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYCLES - 1);
    localparam logic [23:0]   POLL_LAST  = 24'(POLL_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_next;
    logic [7:0]    r_shadow;
    logic [7:0]    w_shadow_next;
    logic [23:0]   r_poll;
    logic          r_req;
    logic          w_wrap;
    logic          w_data;
    logic          w_tc;
    logic          r_latch;
    logic          r_pulse;
    logic          r_valid;
    logic [7:0]    r_controller;

`ifdef CONTROLLER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], ctrl_data};
    end

    assign w_data = r_sync[1];
`else
    assign w_data = ctrl_data;
`endif

    assign w_wrap = (r_poll == POLL_LAST);
    assign w_tc   = (r_timer == '0);

    // A wrap wins over consumption so a request landing on the IDLE cycle is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_poll <= '0;
            r_req  <= 1'b1;
        end else begin
            r_poll <= w_wrap ? 24'd0 : r_poll + 24'd1;
            if (w_wrap)                       r_req <= 1'b1;
            else if (r_state == IDLE && r_req) r_req <= 1'b0;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_timer_next  = r_timer;
        w_idx_next    = r_idx;
        w_shadow_next = r_shadow;
        case (r_state)
            IDLE: begin
                if (r_req) begin
                    w_next       = LATCH;
                    w_timer_next = LATCH_LOAD;
                end
            end
            LATCH: begin
                if (w_tc) begin
                    w_next       = LOW;
                    w_timer_next = HALF_LOAD;
                    w_idx_next   = 3'd0;
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            LOW: begin
                if (w_tc) begin
                    w_shadow_next[r_idx] = ~w_data;
                    w_timer_next         = HALF_LOAD;
                    w_next               = (r_idx == 3'd7) ? DONE : HIGH;
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            HIGH: begin
                if (w_tc) begin
                    w_next       = LOW;
                    w_timer_next = HALF_LOAD;
                    w_idx_next   = r_idx + 3'd1;
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are flop outputs aligned with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_latch      <= 1'b0;
            r_pulse      <= 1'b0;
            r_valid      <= 1'b0;
            r_controller <= '0;
        end else begin
            r_state  <= w_next;
            r_timer  <= w_timer_next;
            r_idx    <= w_idx_next;
            r_shadow <= w_shadow_next;
            r_latch  <= (w_next == LATCH);
            r_pulse  <= (w_next == HIGH);
            r_valid  <= (w_next == DONE);
            if (w_next == DONE) r_controller <= w_shadow_next;
        end
    end

    assign ctrl_latch = r_latch;
    assign ctrl_pulse = r_pulse;
    assign controller = r_controller;
    assign valid      = r_valid;

endmodule

// File: tb/tb_controller_reader.sv
// Bench for controller_reader: two instances (slow poll and back-to-back poll) driven by pad models,
// checked every cycle against a frame-offset timing model plus hand-computed literal expectations.
module tb_controller_reader;
    localparam int HC     = 3;
    localparam int FLAST  = 17 * HC;   // frame offset of the DONE cycle

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] buttons = 8'h09;
    logic [1:0] dat;
    logic [1:0] lat;
    logic [1:0] pul;
    logic [1:0] vld;
    logic [7:0] ctl [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    controller_reader #(.HALF_CYCLES(HC), .POLL_CYCLES(200)) dut_a (
        .clock(clock), .reset(reset), .ctrl_data(dat[0]), .ctrl_latch(lat[0]),
        .ctrl_pulse(pul[0]), .controller(ctl[0]), .valid(vld[0]));

    controller_reader #(.HALF_CYCLES(HC), .POLL_CYCLES(20)) dut_b (
        .clock(clock), .reset(reset), .ctrl_data(dat[1]), .ctrl_latch(lat[1]),
        .ctrl_pulse(pul[1]), .controller(ctl[1]), .valid(vld[1]));

    // Pad: reloads while latch is high, shifts on pulse rise, drives pressed buttons as 0.
    logic [7:0] pad_sr [2] = '{8'h00, 8'h00};
    logic [1:0] pad_prev = 2'b00;
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (lat[i])                      pad_sr[i] <= buttons;
            else if (pul[i] && !pad_prev[i]) pad_sr[i] <= {1'b0, pad_sr[i][7:1]};
            pad_prev[i] <= pul[i];
        end
    end
    assign dat[0] = ~pad_sr[0][0];
    assign dat[1] = ~pad_sr[1][0];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: cycle number since reset release, first LATCH cycle of the current frame, pending request.
    int         m_n   [2];
    int         m_fs  [2];
    bit         m_req [2];
    logic [7:0] m_lat [2];
    logic [7:0] m_ctl [2];
    bit         just_rst = 1'b1;

    function automatic int poll_of(input int i);
        return (i == 0) ? 200 : 20;
    endfunction

    function automatic int tof(input int i);
        if (m_fs[i] >= 0 && m_n[i] >= m_fs[i] && m_n[i] - m_fs[i] <= FLAST) return m_n[i] - m_fs[i];
        return -1;
    endfunction

    task automatic step(input int i);
        bit idle;
        bit r;
        idle = (tof(i) < 0);
        r    = m_req[i];
        if (idle && r) m_fs[i] = m_n[i] + 1;
        m_req[i] = (((m_n[i] + 1) % poll_of(i)) == 0) || (r && !idle);
        m_n[i]++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_fs[i] = -1; m_req[i] = 1'b1; m_lat[i] = 8'h00; m_ctl[i] = 8'h00;
        end
        just_rst = 1'b1;
    endtask

    // Observations pinned against literals by the stimulus process.
    int         vcount [2];
    int         vn     [2][3];
    logic [7:0] vc     [2][3];
    int         lat_cnt;
    int         rise_cnt;
    logic [1:0] prev_v;
    logic [1:0] prev_p;

    initial model_reset();

    always @(negedge clock) begin
        int   t;
        logic el, ep, ev;
        if (reset) begin
            for (int i = 0; i < 2; i++)
                chk($sformatf("reset_out%0d", i), {21'd0, ctl[i], lat[i], pul[i], vld[i]}, 32'd0);
            model_reset();
            vcount   = '{0, 0};
            lat_cnt  = 0;
            rise_cnt = 0;
            prev_v   = '0;
            prev_p   = '0;
        end else begin
            if (just_rst) begin
                step(0); step(1);
                just_rst = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                t  = tof(i);
                el = (t >= 0 && t < 2 * HC);
                ep = (t >= 2 * HC && t < FLAST && ((t - 2 * HC) % (2 * HC)) >= HC);
                ev = (t == FLAST);
                if (t == 2 * HC - 1) m_lat[i] = buttons;
                if (ev)              m_ctl[i] = m_lat[i];
                chk($sformatf("frame%0d n=%0d", i, m_n[i]),
                    {21'd0, ctl[i], lat[i], pul[i], vld[i]},
                    {21'd0, m_ctl[i], el, ep, ev});
                chk($sformatf("exclusive%0d", i), {31'd0, lat[i] & pul[i]}, 32'd0);
                chk($sformatf("valid_single%0d", i), {31'd0, vld[i] & prev_v[i]}, 32'd0);
                if (vld[i]) begin
                    if (vcount[i] < 3) begin
                        vn[i][vcount[i]] = m_n[i];
                        vc[i][vcount[i]] = ctl[i];
                    end
                    vcount[i]++;
                end
                prev_v[i] = vld[i];
            end
            if (vcount[0] == 0) begin
                if (lat[0])               lat_cnt++;
                if (pul[0] && !prev_p[0]) rise_cnt++;
            end
            prev_p = pul;
            step(0); step(1);
        end
    end

    task automatic wait_n(input int target);
        for (int k = 0; k < 3000 && m_n[0] < target; k++) begin
            @(posedge clock); #1;
        end
        chk($sformatf("reach_n%0d", target), {31'd0, m_n[0] >= target}, 32'd1);
    endtask

    task automatic release_reset();
        @(negedge clock); #2;
        reset = 1'b0;
    endtask

    initial begin
        int start;
        repeat (3) @(posedge clock);
        release_reset();

        wait_n(60);
        buttons = 8'h00;
        wait_n(260);
        buttons = 8'hA5;
        wait_n(460);

        chk("lat_cycles",  lat_cnt,  6);
        chk("pulse_rises", rise_cnt, 7);
        chk("a_v1_n",   vn[0][0], 52);
        chk("a_v1_ctl", {24'd0, vc[0][0]}, 32'h09);
        chk("a_v2_n",   vn[0][1], 252);
        chk("a_v2_ctl", {24'd0, vc[0][1]}, 32'h00);
        chk("a_v3_n",   vn[0][2], 452);
        chk("a_v3_ctl", {24'd0, vc[0][2]}, 32'hA5);
        chk("b_v1_n",   vn[1][0], 52);
        chk("b_v1_ctl", {24'd0, vc[1][0]}, 32'h09);
        chk("b_v2_n",   vn[1][1], 105);
        chk("b_v3_n",   vn[1][2], 158);

        for (int k = 0; k < 1500; k++) begin
            @(posedge clock); #1;
            if ($urandom_range(39, 0) == 0) buttons = 8'($urandom);
        end

        buttons = 8'h3C;
        start = m_n[0];
        wait_n(start + 220);

        for (int k = 0; k < 400 && !(m_fs[0] >= 0 && m_n[0] - m_fs[0] == 2 * HC + 4 * 2 * HC + 1); k++) begin
            @(posedge clock); #3;
        end
        chk("found_low_bit4", {31'd0, (m_fs[0] >= 0 && m_n[0] - m_fs[0] == 2 * HC + 4 * 2 * HC + 1)}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_a", {21'd0, ctl[0], lat[0], pul[0], vld[0]}, 32'd0);
        chk("rst_async_b", {21'd0, ctl[1], lat[1], pul[1], vld[1]}, 32'd0);
        repeat (2) @(negedge clock);
        buttons = 8'h5A;
        release_reset();

        wait_n(260);
        chk("r_lat_cycles",  lat_cnt,  6);
        chk("r_pulse_rises", rise_cnt, 7);
        chk("r_v1_n",   vn[0][0], 52);
        chk("r_v1_ctl", {24'd0, vc[0][0]}, 32'h5A);
        chk("r_v2_n",   vn[0][1], 252);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
